// File: rtl/fp_add_norm_round_if.sv
// Valid/ready bundle between fp_adder, this normalize/round stage and the
// downstream consumer of packed binary32 results.
interface fp_add_norm_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic [1:0]  in_special;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_special, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_special, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_add_norm_round.sv
// Two-stage normalize + round-to-nearest-even for the fp_adder raw sum,
// producing packed binary32 with {overflow, underflow, inexact, zero}.
module fp_add_norm_round (
  input logic                clk,
  input logic                rst,
  fp_add_norm_round_if.slave bus
);

  localparam logic [1:0] K_FIN  = 2'd0;
  localparam logic [1:0] K_INF  = 2'd1;
  localparam logic [1:0] K_NAN  = 2'd2;
  localparam logic [1:0] K_ZERO = 2'd3;

  logic        w_s1_ready;
  logic        w_s2_ready;

  logic        r_s1_valid;
  logic        r_s1_sign;
  logic [9:0]  r_s1_exp;
  logic [26:0] r_s1_mant;
  logic [1:0]  r_s1_kind;

  logic        r_s2_valid;
  logic [31:0] r_s2_result;
  logic [3:0]  r_s2_flags;

  assign w_s2_ready = !r_s2_valid || bus.out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;

  assign bus.in_ready   = w_s1_ready;
  assign bus.out_valid  = r_s2_valid;
  assign bus.out_result = r_s2_result;
  assign bus.out_flags  = r_s2_flags;

  logic [4:0]  w_lz;
  logic [7:0]  w_lim;
  logic [4:0]  w_sh;
  logic [26:0] w_m;
  logic [9:0]  w_e;
  logic [1:0]  w_kind;

  always_comb begin
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++)
      if (bus.in_mant[i]) w_lz = 5'(26 - i);
  end

  // Left shift is capped so the exponent bottoms out at 1 (denormal).
  assign w_lim = (bus.in_exp == 8'd0) ? 8'd0 : bus.in_exp - 8'd1;
  assign w_sh  = ({3'b0, w_lz} < w_lim) ? w_lz : w_lim[4:0];

  always_comb begin
    w_kind = K_FIN;
    w_m    = '0;
    w_e    = {2'b0, bus.in_exp};
    if (bus.in_special[1]) begin
      w_kind = K_NAN;
    end else if (bus.in_special[0]) begin
      w_kind = K_INF;
    end else if (bus.in_mant[27]) begin
      w_m = {bus.in_mant[27:2], |bus.in_mant[1:0]};
      w_e = w_e + 10'd1;
    end else if (bus.in_mant[26:0] == 27'd0) begin
      w_kind = K_ZERO;
    end else begin
      w_m = bus.in_mant[26:0] << w_sh;
      w_e = w_e - {5'b0, w_sh};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mant  <= '0;
      r_s1_kind  <= K_FIN;
    end else if (w_s1_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_sign <= bus.in_sign;
        r_s1_exp  <= w_e;
        r_s1_mant <= w_m;
        r_s1_kind <= w_kind;
      end
    end
  end

  logic        w_rup;
  logic        w_inx;
  logic [24:0] w_sum;
  logic [9:0]  w_ef;
  logic [22:0] w_frac;
  logic [31:0] w_res;
  logic [3:0]  w_flg;

  assign w_rup = r_s1_mant[2] & (|r_s1_mant[1:0] | r_s1_mant[3]);
  assign w_inx = |r_s1_mant[2:0];
  assign w_sum = {1'b0, r_s1_mant[26:3]} + {24'b0, w_rup};

  // Integer bit after rounding decides normal vs denormal exponent field.
  assign w_ef   = w_sum[24] ? r_s1_exp + 10'd1
                : (w_sum[23] ? r_s1_exp : 10'd0);
  assign w_frac = w_sum[24] ? 23'd0 : w_sum[22:0];

  always_comb begin
    w_res = {r_s1_sign, w_ef[7:0], w_frac};
    w_flg = {1'b0, (w_ef == 10'd0) & w_inx, w_inx, 1'b0};
    w_flg[0] = (w_res[30:0] == 31'd0);
    case (r_s1_kind)
      K_ZERO: begin
        w_res = {r_s1_sign, 31'd0};
        w_flg = 4'b0001;
      end
      K_INF: begin
        w_res = {r_s1_sign, 8'hFF, 23'd0};
        w_flg = 4'b0000;
      end
      K_NAN: begin
        w_res = 32'h7FC0_0000;
        w_flg = 4'b0000;
      end
      default: begin
        if (w_ef >= 10'd255) begin
          w_res = {r_s1_sign, 8'hFF, 23'd0};
          w_flg = 4'b1010;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_res;
        r_s2_flags  <= w_flg;
      end
    end
  end

endmodule
